// File: rtl/fsm_arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority grant arbiter.
package fsm_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index of the set bit of a one-hot (or zero) vector of up to 16 agents.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: rotate eligible requests so the start pointer
// sits at bit 0, take the first set bit, then rotate the index back.
module arb_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] excl,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   start;
  logic [NUM_REQ-1:0] rot;

  assign elig  = req & ~excl;
  // Fixed priority is just round robin anchored at index 0.
  assign start = mode ? ptr : '0;

  // Rotate, find-first-set, rotate back.
  always_comb begin
    int j;
    int off;
    int sum;
    j       = 0;
    off     = 0;
    sum     = 0;
    rot     = '0;
    win_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = i + int'(start);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rot[i] = elig[j[IDX_W-1:0]];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = i;
    any = |rot;
    sum = off + int'(start);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    win_idx = sum[IDX_W-1:0];
    for (int i = 0; i < NUM_REQ; i++)
      win_oh[i] = any && (i == sum);
  end

endmodule

// File: rtl/fsm_arbiter_rr.sv
// Registered one-hot grant arbiter with fixed-priority or round-robin
// selection and an optional hold limit that preempts a long-running owner.
module fsm_arbiter_rr
  import fsm_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MODE     = 1,
  parameter  int MAX_HOLD = 8,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               preempt
);

  localparam logic       RR        = (MODE == MODE_RR);
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t             state, state_nxt;
  logic [7:0]         hold_cnt, hold_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               preempt_nxt;
  logic               take;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               own, others;

  assign own    = |(req & gnt);
  assign others = |(req & ~gnt);

  // The current owner is always excluded: on a handoff its req is already
  // low, and on a preempt it must lose this one arbitration.
  arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .excl    (gnt),
    .ptr     (ptr),
    .mode    (RR),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= IDX_W'(onehot_to_idx(16'(gnt_nxt)));
      preempt   <= preempt_nxt;
      hold_cnt  <= hold_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // Next state: leave GRANT only when nobody at all is requesting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (!own && !others) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next grant, preempt pulse, hold counter and round-robin pointer.
  always_comb begin
    gnt_nxt     = gnt;
    preempt_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    ptr_nxt     = ptr;
    take        = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        take    = win_any;
      end
      GRANT: begin
        if (!own) begin
          if (others) take = 1'b1;
          else        gnt_nxt = '0;
        end else if (HOLD_EN && hold_cnt == HOLD_LAST && others) begin
          take        = 1'b1;
          preempt_nxt = 1'b1;
        end else if (HOLD_EN && others && hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: gnt_nxt = '0;
    endcase
    if (take) begin
      gnt_nxt  = win_oh;
      hold_nxt = '0;
      ptr_nxt  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Bench for fsm_arbiter_rr: three configurations share one req stream and
// are checked every cycle against a behavioural model, plus directed
// literal expectations.
module tb_fsm_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;

  // 0: round robin, no hold limit; 1: fixed priority; 2: round robin, hold 4
  logic [3:0] gnt_o [3];
  logic       gv_o  [3];
  logic [1:0] gid_o [3];
  logic       pre_o [3];

  int mode_p [3] = '{1, 0, 1};
  int mh_p   [3] = '{0, 0, 4};

  int m_own  [3] = '{-1, -1, -1};
  int m_hold [3] = '{0, 0, 0};
  int m_ptr  [3] = '{0, 0, 0};
  bit m_pre  [3] = '{0, 0, 0};

  int errors = 0;
  int checks = 0;

  fsm_arbiter_rr #(.NUM_REQ(4), .MODE(1), .MAX_HOLD(0)) dut_rr0 (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt_o[0]), .gnt_valid(gv_o[0]), .gnt_id(gid_o[0]), .preempt(pre_o[0]));

  fsm_arbiter_rr #(.NUM_REQ(4), .MODE(0), .MAX_HOLD(0)) dut_fp (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt_o[1]), .gnt_valid(gv_o[1]), .gnt_id(gid_o[1]), .preempt(pre_o[1]));

  fsm_arbiter_rr #(.NUM_REQ(4), .MODE(1), .MAX_HOLD(4)) dut_rr4 (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt_o[2]), .gnt_valid(gv_o[2]), .gnt_id(gid_o[2]), .preempt(pre_o[2]));

  initial forever #5 clock = ~clock;

  // First requester at or after the start point (wrapping), skipping excl.
  function automatic int mpick(logic [3:0] r, int excl, int ptr, int mode);
    int s;
    s = (mode != 0) ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (s + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic mgrant(int k, int w);
    m_own[k]  = w;
    m_hold[k] = 0;
    m_ptr[k]  = (w + 1) % 4;
  endtask

  task automatic mstep(int k, logic [3:0] r);
    int o;
    bit oth;
    o = m_own[k];
    m_pre[k] = 1'b0;
    if (o < 0) begin
      if (r != 4'b0000) mgrant(k, mpick(r, -1, m_ptr[k], mode_p[k]));
    end else begin
      oth = (r & ~(4'b0001 << o)) != 4'b0000;
      if (!r[o] && !oth) m_own[k] = -1;
      else if (!r[o]) mgrant(k, mpick(r, o, m_ptr[k], mode_p[k]));
      else if (mh_p[k] != 0 && m_hold[k] == mh_p[k] - 1 && oth) begin
        mgrant(k, mpick(r, o, m_ptr[k], mode_p[k]));
        m_pre[k] = 1'b1;
      end else if (oth && mh_p[k] != 0 && m_hold[k] < mh_p[k] - 1)
        m_hold[k] = m_hold[k] + 1;
    end
  endtask

  // Model advances on the same edges as the DUT.
  initial forever begin
    @(posedge clock or posedge reset);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_own[k] = -1; m_hold[k] = 0; m_ptr[k] = 0; m_pre[k] = 1'b0;
      end else
        mstep(k, req);
    end
  end

  // Every-cycle comparison of all three instances against the model.
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      logic [1:0] eid;
      eg  = (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
      eid = (m_own[k] < 0) ? 2'd0 : 2'(m_own[k]);
      checks++;
      if ({gnt_o[k], gv_o[k], gid_o[k], pre_o[k]} !== {eg, (m_own[k] >= 0), eid, m_pre[k]}) begin
        errors++;
        $display("FAIL model[%0d] t=%0t: gnt=%b v=%b id=%0d pre=%b, expected gnt=%b v=%b id=%0d pre=%b",
                 k, $time, gnt_o[k], gv_o[k], gid_o[k], pre_o[k], eg, (m_own[k] >= 0), eid, m_pre[k]);
      end
      checks++;
      if (!$onehot0(gnt_o[k])) begin
        errors++;
        $display("FAIL onehot[%0d] t=%0t: gnt=%b, expected one-hot or zero", k, $time, gnt_o[k]);
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reset pulse issued just after a falling edge so it never coincides
  // with the sampling edge of the compare process.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int owner;
    int fo;

    // Reset state
    @(negedge clock);
    chk("rst_gnt", 8'(gnt_o[0]), 8'h00);
    chk("rst_valid", 8'(gv_o[0]), 8'h00);
    chk("rst_id", 8'(gid_o[0]), 8'h00);
    chk("rst_pre", 8'(pre_o[0]), 8'h00);
    reset = 1'b0;

    // Single request, one-cycle latency, then release
    req = 4'b0001;
    @(negedge clock);
    chk("single_gnt", 8'(gnt_o[0]), 8'h01);
    chk("single_id", 8'(gid_o[0]), 8'h00);
    chk("single_valid", 8'(gv_o[0]), 8'h01);
    req = 4'b0000;
    @(negedge clock);
    chk("release_gnt", 8'(gnt_o[0]), 8'h00);
    chk("release_valid", 8'(gv_o[0]), 8'h00);

    // Each agent alone for 5 cycles
    for (int a = 0; a < 4; a++) begin
      req = 4'(1 << a);
      repeat (5) @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("seq%0d_gnt[%0d]", a, k), 8'(gnt_o[k]), 8'(1 << a));
        chk($sformatf("seq%0d_id[%0d]", a, k), 8'(gid_o[k]), 8'(a));
      end
      req = 4'b0000;
      @(negedge clock);
      chk($sformatf("seq%0d_gap", a), 8'(gv_o[0]), 8'h00);
    end

    // Round robin: owner drops for one cycle, then reasserts
    pulse_reset();
    req = 4'b1111;
    @(negedge clock);
    chk("rr_first", 8'(gnt_o[0]), 8'h01);
    owner = 0;
    for (int i = 0; i < 4; i++) begin
      req = 4'b1111 & ~4'(1 << owner);
      @(negedge clock);
      owner = (owner + 1) % 4;
      chk($sformatf("rr_hand%0d", i), 8'(gnt_o[0]), 8'(1 << owner));
      req = 4'b1111;
      @(negedge clock);
      chk($sformatf("rr_hold%0d", i), 8'(gnt_o[0]), 8'(1 << owner));
    end

    // Fixed priority: handoffs bounce between 0 and 1, agent 3 starves
    pulse_reset();
    req = 4'b1111;
    @(negedge clock);
    chk("fp_first", 8'(gnt_o[1]), 8'h01);
    fo = 0;
    for (int i = 0; i < 4; i++) begin
      req = 4'b1111 & ~4'(1 << fo);
      @(negedge clock);
      fo = (fo == 0) ? 1 : 0;
      chk($sformatf("fp_hand%0d", i), 8'(gnt_o[1]), 8'(1 << fo));
      chk($sformatf("fp_no3_%0d", i), 8'(gnt_o[1][3]), 8'h00);
      req = 4'b1111;
      @(negedge clock);
      chk($sformatf("fp_hold%0d", i), 8'(gnt_o[1]), 8'(1 << fo));
    end

    // Preemption after 4 cycles with a competitor waiting
    pulse_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("pre_own%0d", c), 8'(gnt_o[2]), 8'h01);
      chk($sformatf("pre_low%0d", c), 8'(pre_o[2]), 8'h00);
    end
    @(negedge clock);
    chk("pre_move", 8'(gnt_o[2]), 8'h02);
    chk("pre_pulse", 8'(pre_o[2]), 8'h01);
    @(negedge clock);
    chk("pre_after", 8'(gnt_o[2]), 8'h02);
    chk("pre_once", 8'(pre_o[2]), 8'h00);

    // Lone owner is never preempted
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk($sformatf("lone_gnt%0d", c), 8'(gnt_o[2]), 8'h01);
      chk($sformatf("lone_pre%0d", c), 8'(pre_o[2]), 8'h00);
    end

    // Reset mid-grant clears immediately; first grant after uses ptr=0
    pulse_reset();
    req = 4'b0100;
    @(negedge clock);
    chk("mid_gnt", 8'(gnt_o[0]), 8'h04);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_gnt", 8'(gnt_o[0]), 8'h00);
    chk("mid_async_valid", 8'(gv_o[0]), 8'h00);
    @(negedge clock);
    reset = 1'b0;
    req = 4'b1010;
    @(negedge clock);
    chk("post_rst_rr", 8'(gnt_o[0]), 8'h02);
    chk("post_rst_id", 8'(gid_o[0]), 8'h01);
    chk("post_rst_fp", 8'(gnt_o[1]), 8'h02);

    req = 4'b0000;
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
